wave_gen: RTL and testbench

WAVE_GEN -- requirements
Module: wave_gen

---
 rtl/wave_gen.sv | 127 ++++++++++++
 tb/tb_wave_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - multi-channel PWM waveform generator with burst control
//
// Ports:
//   clk          single clock, all state changes on rising edge
//   rst          synchronous active-high reset
//   cfg_we       config write strobe (accepted only in IDLE)
//   cfg_ch       channel selected by a config write
//   cfg_period   period P in clk cycles
//   cfg_high     high time H in clk cycles
//   cfg_burst    burst length B in channel-0 periods, 0 = continuous
//   start        level-sampled run request
//   stop         level-sampled abort request
//   sig          registered per-channel waveform outputs
//   period_tick  per-channel pulse on the last cycle of each period
//   busy         high while running
//   done         one-cycle pulse on burst completion
module wave_gen #(
    parameter int NCH     = 4,
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                       cfg_period,
    input  logic [CNT_W-1:0]                       cfg_high,
    input  logic [BURST_W-1:0]                     cfg_burst,
    input  logic                                   start,
    input  logic                                   stop,
    output logic [NCH-1:0]                         sig,
    output logic [NCH-1:0]                         period_tick,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state, state_n;
    logic [CNT_W-1:0]   p_q   [NCH];
    logic [CNT_W-1:0]   h_q   [NCH];
    logic [CNT_W-1:0]   cnt_q [NCH];
    logic [CNT_W-1:0]   p_n   [NCH];
    logic [CNT_W-1:0]   h_n   [NCH];
    logic [CNT_W-1:0]   cnt_n [NCH];
    logic [BURST_W-1:0] b_q, b_n;
    logic [BURST_W-1:0] bcnt_q, bcnt_n;
    logic [NCH-1:0]     sig_n, tick_n;
    logic               cfg_ok, go, fin;

    // Outputs are registered, so everything is computed from next-state
    // values; this lets a config write coincident with start shape the
    // very first cycle of the run.
    always_comb begin
        cfg_ok = (state == S_IDLE) && cfg_we && (int'(cfg_ch) < NCH);
        go     = (state == S_IDLE) && start && !stop;
        // period_tick[0] is the current-cycle tick; the B-th one ends the burst
        fin    = (state == S_RUN) && !stop && period_tick[0] &&
                 (b_q != '0) && (bcnt_q == b_q - BURST_W'(1));

        state_n = state;
        case (state)
            S_IDLE:  if (go) state_n = S_RUN;
            S_RUN:   if (stop) state_n = S_IDLE;
                     else if (fin) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase

        b_n = cfg_ok ? cfg_burst : b_q;

        // Saturating so continuous runs never wrap into a false completion.
        bcnt_n = '0;
        if (state == S_RUN && state_n == S_RUN)
            bcnt_n = (period_tick[0] && bcnt_q != '1) ? bcnt_q + BURST_W'(1) : bcnt_q;

        for (int i = 0; i < NCH; i++) begin
            p_n[i] = (cfg_ok && cfg_ch == CHW'(i)) ? cfg_period : p_q[i];
            h_n[i] = (cfg_ok && cfg_ch == CHW'(i)) ? cfg_high   : h_q[i];

            cnt_n[i] = '0;
            if (state == S_RUN && state_n == S_RUN && p_q[i] >= CNT_W'(2) &&
                cnt_q[i] != p_q[i] - CNT_W'(1))
                cnt_n[i] = cnt_q[i] + CNT_W'(1);

            // P < 2 is degenerate: output stays low and never ticks.
            sig_n[i]  = (state_n == S_RUN) && (p_n[i] >= CNT_W'(2)) &&
                        (cnt_n[i] < h_n[i]);
            tick_n[i] = (state_n == S_RUN) && (p_n[i] >= CNT_W'(2)) &&
                        (cnt_n[i] == p_n[i] - CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            b_q         <= '0;
            bcnt_q      <= '0;
            sig         <= '0;
            period_tick <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                p_q[i]   <= CNT_W'(2);
                h_q[i]   <= CNT_W'(1);
                cnt_q[i] <= '0;
            end
        end else begin
            state       <= state_n;
            b_q         <= b_n;
            bcnt_q      <= bcnt_n;
            sig         <= sig_n;
            period_tick <= tick_n;
            busy        <= (state_n == S_RUN);
            done        <= (state_n == S_DONE);
            for (int i = 0; i < NCH; i++) begin
                p_q[i]   <= p_n[i];
                h_q[i]   <= h_n[i];
                cnt_q[i] <= cnt_n[i];
            end
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// tb/tb_wave_gen.sv - directed self-checking bench for wave_gen
//
// Ports: none (top-level bench). Drives wave_gen with NCH=5 so that
// cfg_ch = NCH is representable on the 3-bit channel select.
module tb_wave_gen;

    localparam int NCH = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [7:0]     cfg_period;
    logic [7:0]     cfg_high;
    logic [7:0]     cfg_burst;
    logic           start;
    logic           stop;
    logic [NCH-1:0] sig;
    logic [NCH-1:0] period_tick;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    wave_gen #(.NCH(NCH), .CNT_W(8), .BURST_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_burst(cfg_burst),
        .start(start), .stop(stop), .sig(sig), .period_tick(period_tick),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int ch, input int p, input int h, input int b);
        cfg_we     = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
        cfg_burst  = 8'(b);
        step();
        cfg_we     = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sig"},  32'(sig), 32'h0);
        chk({tag, "_tick"}, 32'(period_tick), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
        cfg_burst = '0; start = 1'b0; stop = 1'b0;

        // reset state
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();

        // start with stop together in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 32'h0);

        // defaults: every channel square wave period 2
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("dflt_sig",  32'(sig), (k % 2 == 0) ? 32'h1f : 32'h0);
            chk("dflt_tick", 32'(period_tick), (k % 2 == 1) ? 32'h1f : 32'h0);
            chk("dflt_busy", 32'(busy), 32'h1);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("dflt_stop");

        // ch0 P=5 H=2, burst of 3
        cfg(0, 5, 2, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("b3_sig0",  32'(sig[0]), ((k % 5) < 2) ? 32'h1 : 32'h0);
            chk("b3_tick0", 32'(period_tick[0]), ((k % 5) == 4) ? 32'h1 : 32'h0);
            chk("b3_busy",  32'(busy), 32'h1);
            chk("b3_done",  32'(done), 32'h0);
            step();
        end
        chk("b3_done_pulse", 32'(done), 32'h1);
        chk("b3_done_busy",  32'(busy), 32'h0);
        chk("b3_done_sig",   32'(sig), 32'h0);
        chk("b3_done_tick",  32'(period_tick), 32'h0);
        step();
        chk_idle("b3_after");

        // degenerate channel configs, continuous run
        cfg(1, 4, 0, 0);
        cfg(2, 3, 7, 0);
        cfg(3, 1, 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("deg_sig123", 32'(sig[3:1]), 32'h2);
            chk("deg_tick3",  32'(period_tick[3]), 32'h0);
            chk("deg_tick2",  32'(period_tick[2]), ((k % 3) == 2) ? 32'h1 : 32'h0);
            chk("deg_tick1",  32'(period_tick[1]), ((k % 4) == 3) ? 32'h1 : 32'h0);
            step();
        end
        chk("deg_busy", 32'(busy), 32'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("deg_stop");

        // stop on the cycle of the 2nd channel-0 tick beats completion
        cfg(0, 5, 2, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk("stp_done", 32'(done), 32'h0);
            step();
        end
        chk("stp_tick0", 32'(period_tick[0]), 32'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("stp_next");
        step();
        chk("stp_done_later", 32'(done), 32'h0);

        // config writes during RUN and to an out-of-range channel are ignored
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd9; cfg_high = 8'd3; cfg_burst = 8'd0;
        step();
        step();
        cfg_we = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        cfg(NCH, 9, 3, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("ign_sig0",  32'(sig[0]), ((k % 5) < 2) ? 32'h1 : 32'h0);
            chk("ign_tick0", 32'(period_tick[0]), ((k % 5) == 4) ? 32'h1 : 32'h0);
            step();
        end
        chk("ign_done", 32'(done), 32'h1);
        step();

        // reset mid-run with start held high
        start = 1'b1;
        step();
        step();
        step();
        chk("rst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        chk_idle("rst_mid");
        step();
        chk("rst_hold_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("rst_sig",  32'(sig), (k % 2 == 0) ? 32'h1f : 32'h0);
            chk("rst_tick", 32'(period_tick), (k % 2 == 1) ? 32'h1f : 32'h0);
            chk("rst_busy", 32'(busy), 32'h1);
            chk("rst_done", 32'(done), 32'h0);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("rst_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
